// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, per-boundary control widths and payload field offsets
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_CTRL_W  = 9;
    localparam int EXMEM_CTRL_W = 5;
    localparam int MEMWB_CTRL_W = 2;
    localparam int PC_OFF   = 0;
    localparam int OPA_OFF  = 32;
    localparam int OPB_OFF  = 64;
    localparam int IMM_OFF  = 96;
    localparam int TAG_OFF  = 120;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous clear
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= !rst ? '0 : clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with optional skid entry, flush and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);
    logic [1:0]        state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              ready_q, accept, drain, load_main, load_skid, shift;
    assign out_valid = state != ST_EMPTY;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign in_ready  = (SKID != 0) ? ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    always_comb begin
        state_nxt = (state == ST_EMPTY) ? (accept ? ST_ONE : ST_EMPTY)
                  : (state == ST_ONE)   ? ((accept && !drain) ? ST_TWO : (drain && !accept) ? ST_EMPTY : ST_ONE)
                  : (drain ? ST_ONE : ST_TWO);
        load_main = accept && (state == ST_EMPTY || (state == ST_ONE && drain));
        load_skid = accept && state == ST_ONE && !drain;
        shift     = drain && state == ST_TWO;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            ready_q   <= 1'b1;
            main_ctrl <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            ready_q   <= 1'b1;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= state_nxt != ST_TWO;
            if (load_main) begin
                main_ctrl <= in_ctrl;
                out_data  <= in_data;
            end else if (shift) begin
                main_ctrl <= skid_ctrl;
                out_data  <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end
    pipe_sat_counter #(.W(CNT_W)) u_stall (
        .clk(clk),
        .rst(rst),
        .clr(stall_clr),
        .inc(out_valid && !out_ready),
        .cnt(stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of a skid instance and a single-entry instance
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        stall_clr = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [7:0]  out_ctrl;
    logic [15:0] out_data;
    logic [3:0]  stall_cnt;
    logic        in_valid0 = 1'b0, out_ready0 = 1'b1;
    logic        in_ready0, out_valid0;
    logic [7:0]  out_ctrl0;
    logic [15:0] out_data0;
    logic [3:0]  stall_cnt0;
    int          passed = 0, failed = 0, total = 0;
    always #5 clk = ~clk;
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .stall_cnt(stall_cnt0), .stall_clr(stall_clr)
    );
    function automatic logic [15:0] dat(input logic [7:0] c);
        return {c, ~c};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic offer(input logic v, input logic [7:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = dat(c);
        #1;
    endtask
    initial begin
        offer(1'b1, 8'hFF);
        tick;
        tick;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_valid0", {31'd0, out_valid0}, 32'd0);
        rst = 1'b1;
        offer(1'b0, 8'h00);
        tick;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            offer(1'b1, 8'(i));
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
            tick;
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_ctrl", {24'd0, out_ctrl}, 32'(i));
            chk("stream_data", {16'd0, out_data}, {16'd0, dat(8'(i))});
        end
        offer(1'b0, 8'h00);
        tick;
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("stream_cnt", {28'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        offer(1'b1, 8'hA1);
        tick;
        chk("skid_a1_ctrl", {24'd0, out_ctrl}, 32'hA1);
        chk("skid_one_ready", {31'd0, in_ready}, 32'd1);
        offer(1'b1, 8'hA2);
        tick;
        chk("skid_two_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_two_ctrl", {24'd0, out_ctrl}, 32'hA1);
        offer(1'b1, 8'hA3);
        tick;
        chk("skid_hold_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_hold_ctrl", {24'd0, out_ctrl}, 32'hA1);
        out_ready = 1'b1;
        #1;
        chk("drain_a1", {24'd0, out_ctrl}, 32'hA1);
        tick;
        chk("drain_a2", {24'd0, out_ctrl}, 32'hA2);
        chk("drain_a2_data", {16'd0, out_data}, {16'd0, dat(8'hA2)});
        chk("drain_ready", {31'd0, in_ready}, 32'd1);
        tick;
        chk("drain_a3", {24'd0, out_ctrl}, 32'hA3);
        chk("drain_a3_data", {16'd0, out_data}, {16'd0, dat(8'hA3)});
        offer(1'b0, 8'h00);
        tick;
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("skid_cnt", {28'd0, stall_cnt}, 32'd2);
        stall_clr = 1'b1;
        tick;
        stall_clr = 1'b0;
        chk("clr_cnt", {28'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        offer(1'b1, 8'hB1);
        tick;
        offer(1'b1, 8'hB2);
        tick;
        chk("flush_pre_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        offer(1'b1, 8'hC3);
        tick;
        flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_data_kept", {16'd0, out_data}, {16'd0, dat(8'hB1)});
        chk("flush_cnt_kept", {28'd0, stall_cnt}, 32'd2);
        out_ready = 1'b1;
        offer(1'b0, 8'h00);
        tick;
        chk("c3_dropped", {31'd0, out_valid}, 32'd0);
        offer(1'b1, 8'hD4);
        tick;
        chk("d4_valid", {31'd0, out_valid}, 32'd1);
        chk("d4_ctrl", {24'd0, out_ctrl}, 32'hD4);
        offer(1'b1, 8'hE5);
        tick;
        chk("e5_ctrl", {24'd0, out_ctrl}, 32'hE5);
        flush = 1'b1;
        offer(1'b1, 8'hE6);
        chk("flush_one_ready", {31'd0, in_ready}, 32'd1);
        tick;
        flush = 1'b0;
        offer(1'b0, 8'h00);
        chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
        tick;
        chk("e6_dropped", {31'd0, out_valid}, 32'd0);
        stall_clr = 1'b1;
        out_ready = 1'b0;
        offer(1'b1, 8'h55);
        tick;
        stall_clr = 1'b0;
        offer(1'b0, 8'h00);
        chk("sat_start", {28'd0, stall_cnt}, 32'd0);
        repeat (14) tick;
        chk("sat_14", {28'd0, stall_cnt}, 32'd14);
        repeat (6) tick;
        chk("sat_15", {28'd0, stall_cnt}, 32'd15);
        stall_clr = 1'b1;
        tick;
        stall_clr = 1'b0;
        chk("sat_clr", {28'd0, stall_cnt}, 32'd0);
        tick;
        chk("sat_resume", {28'd0, stall_cnt}, 32'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        out_ready = 1'b1;
        out_ready0 = 1'b0;
        in_valid0 = 1'b1;
        offer(1'b0, 8'h61);
        chk("s0_empty_ready", {31'd0, in_ready0}, 32'd1);
        tick;
        chk("s0_61_ctrl", {24'd0, out_ctrl0}, 32'h61);
        offer(1'b0, 8'h62);
        chk("s0_full_ready", {31'd0, in_ready0}, 32'd0);
        tick;
        chk("s0_held_ctrl", {24'd0, out_ctrl0}, 32'h61);
        out_ready0 = 1'b1;
        #1;
        chk("s0_comb_ready", {31'd0, in_ready0}, 32'd1);
        tick;
        chk("s0_62_valid", {31'd0, out_valid0}, 32'd1);
        chk("s0_62_ctrl", {24'd0, out_ctrl0}, 32'h62);
        chk("s0_62_data", {16'd0, out_data0}, {16'd0, dat(8'h62)});
        in_valid0 = 1'b0;
        tick;
        chk("s0_empty_valid", {31'd0, out_valid0}, 32'd0);
        chk("s0_empty_ctrl", {24'd0, out_ctrl0}, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
